// File: rtl/ifetch_queue_pkg.sv
// rtl/ifetch_queue_pkg.sv - shared defaults and sizing helper for the instruction prefetch queue
package ifetch_queue_pkg;

  localparam int ADDR_W_DEF     = 16;
  localparam int INST_W_DEF     = 16;
  localparam int DEPTH_DEF      = 4;
  localparam int RESET_ADDR_DEF = 0;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ifetch_queue_if.sv
// rtl/ifetch_queue_if.sv - memory, decode and redirect signals of the prefetch queue
interface ifetch_queue_if
  import ifetch_queue_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int INST_W = INST_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  localparam int CNT_W = cnt_w(DEPTH)
) ();

  logic              branch_i;
  logic [ADDR_W-1:0] baddr_i;
  logic              stall_i;
  logic              fe_o;
  logic [ADDR_W-1:0] addr_o;
  logic [INST_W-1:0] inst_i;
  logic              v_o;
  logic [INST_W-1:0] inst_o;
  logic [ADDR_W-1:0] origaddr_o;
  logic [CNT_W-1:0]  count_o;

  // The prefetch queue itself.
  modport master (
    input  branch_i, baddr_i, stall_i, inst_i,
    output fe_o, addr_o, v_o, inst_o, origaddr_o, count_o
  );

  // Surroundings: memory, decode and execute.
  modport slave (
    output branch_i, baddr_i, stall_i, inst_i,
    input  fe_o, addr_o, v_o, inst_o, origaddr_o, count_o
  );

endinterface

// File: rtl/ifetch_queue_fetch_fifo.sv
// rtl/ifetch_queue_fetch_fifo.sv - first-word-fall-through FIFO with synchronous flush
module ifetch_queue_fetch_fifo
  import ifetch_queue_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CNT_W = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [W-1:0]     data_i,
  input  logic             pop_i,
  output logic [W-1:0]     data_o,
  output logic [CNT_W-1:0] count_o
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW-1:0]    wr_q, wr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full, empty, push_ok, pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign push_ok = push_i & (~full | pop_i);
  assign pop_ok  = pop_i & ~empty;

  // Pointer and occupancy next state; flush wins over any push or pop.
  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (flush_i) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      if (push_ok) wr_d = wr_q + AW'(1);
      if (pop_ok)  rd_d = rd_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Storage and pointer registers; storage is cleared so the head reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_ok && !flush_i) mem_q[wr_q] <= data_i;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  assign data_o  = mem_q[rd_q];
  assign count_o = count_q;

endmodule

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - sequential instruction prefetch with branch redirect and decode buffering
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int              ADDR_W     = ADDR_W_DEF,
  parameter int              INST_W     = INST_W_DEF,
  parameter int              DEPTH      = DEPTH_DEF,
  parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_ADDR_DEF),
  localparam int             CNT_W      = cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  ifetch_queue_if.master bus
);

  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] resp_addr_q, resp_addr_d;
  logic              inflight_q, inflight_d;
  logic              squash_q, squash_d;

  logic              fe, push, pop, valid;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    occupancy;
  logic [INST_W+ADDR_W-1:0] head;

  // Slots already committed: buffered entries plus the one still coming back from memory.
  assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight_q};
  // Issue only when a returning word is guaranteed a slot; held low while in reset.
  assign fe        = rst & (occupancy < DEPTH_C);
  assign valid     = (count != '0);
  // A redirect kills both the returning word and any pop of stale entries.
  assign push      = inflight_q & ~squash_q & ~bus.branch_i;
  assign pop       = valid & ~bus.stall_i & ~bus.branch_i;

  // PC advance, in-flight tracking and squash marking for the request issued during a redirect.
  always_comb begin
    pc_d        = pc_q;
    resp_addr_d = resp_addr_q;
    inflight_d  = fe;
    squash_d    = 1'b0;
    if (fe) begin
      pc_d        = pc_q + ADDR_W'(1);
      resp_addr_d = pc_q;
    end
    if (bus.branch_i) begin
      pc_d     = bus.baddr_i;
      squash_d = fe;
    end
  end

  // Fetch-side state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q        <= RESET_ADDR;
      resp_addr_q <= '0;
      inflight_q  <= 1'b0;
      squash_q    <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      resp_addr_q <= resp_addr_d;
      inflight_q  <= inflight_d;
      squash_q    <= squash_d;
    end
  end

  ifetch_queue_fetch_fifo #(
    .W     (INST_W + ADDR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .flush_i (bus.branch_i),
    .push_i  (push),
    .data_i  ({bus.inst_i, resp_addr_q}),
    .pop_i   (pop),
    .data_o  (head),
    .count_o (count)
  );

  assign bus.fe_o       = fe;
  assign bus.addr_o     = pc_q;
  assign bus.v_o        = valid;
  assign bus.inst_o     = head[INST_W+ADDR_W-1:ADDR_W];
  assign bus.origaddr_o = head[ADDR_W-1:0];
  assign bus.count_o    = count;

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction prefetch stage between instruction memory and the decode stage of the core.
- Generates sequential fetch addresses, issues them to the synchronous instruction memory, and buffers returned instructions with their addresses in a small FIFO.
- Presents the FIFO head to decode with a valid flag, holds it under decode stall, and flushes and redirects on a branch from execute.

Parameters:
- ADDR_W, 16, instruction address width (word addressed).
- INST_W, 16, instruction word width.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- RESET_ADDR, 0, first fetch address after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- branch_i  in  1  redirect request from execute.
- baddr_i  in  ADDR_W  branch target; valid only when branch_i=1.
- stall_i  in  1  decode cannot accept the current instruction.
- fe_o  out  1  fetch enable to instruction memory.
- addr_o  out  ADDR_W  fetch address; equal to the PC register.
- inst_i  in  INST_W  memory read data, valid the cycle after fe_o=1.
- v_o  out  1  head entry valid to decode.
- inst_o  out  INST_W  head instruction.
- origaddr_o  out  ADDR_W  address of the head instruction.
- count_o  out  $clog2(DEPTH+1)  FIFO occupancy.

Behaviour:
Reset (async, rst=0):
- pc=RESET_ADDR, FIFO empty, inflight=0, squash=0.
- Outputs: v_o=0, count_o=0, inst_o=0, origaddr_o=0, addr_o=RESET_ADDR, fe_o=0 while rst=0.
- Reset asserted mid-operation discards all queued and in-flight state immediately.

Issue:
- fe_o = (count + inflight < DEPTH); combinational from registered state only. branch_i does not gate it.
- At the edge when fe_o=1: pc <= pc+1 (wraps modulo 2^ADDR_W), inflight <= 1, and the issued address is latched as resp_addr.
- When fe_o=0: inflight <= 0 and pc holds.

Response:
- The cycle after issue (inflight=1), {inst_i, resp_addr} is pushed at the edge unless squash=1 or branch_i=1.
- Memory latency is fixed at 1 cycle.

Output:
- First-word-fall-through: v_o = count != 0; inst_o and origaddr_o come from the head entry.
- Pop at the edge when v_o & ~stall_i & ~branch_i.
- Pop and push in the same cycle are legal; count is unchanged.
- Head fields hold stable while stall_i=1.

Branch (priority over pop, push and stall):
- At the edge with branch_i=1: FIFO cleared, pc <= baddr_i, squash <= inflight_next (the request issued this cycle is dropped on return).
- The cycle-B+1 response is always discarded.
- Timeline: branch in cycle B → addr_o=baddr_i in B+1 → pushed at end of B+2 → v_o=1 in B+3.
- Back-to-back branches: the last one wins.

Latency and throughput:
- After reset release, the first v_o=1 is 2 cycles after the first fe_o=1.
- Sustained rate is 1 instruction/cycle with stall_i=0.
- Full: fe_o=0 while count+inflight=DEPTH; no instruction is ever lost or duplicated.

Decomposition:
- params.vh holds ADDR_W, INST_W, DEPTH and RESET_ADDR defaults.
- Natural sub-module: fetch_fifo, a DEPTH-entry FWFT FIFO with synchronous flush, push, pop and count.
- PC, issue logic and squash logic stay in ifetch_queue.

Test Plan:
1. Reset, then release with a memory model returning inst=addr^16'hA5A5 → fe_o=1 in cycle 0 with addr_o=0000; v_o=1 in cycle 2 with origaddr 0000 and inst A5A5; then addresses 0001, 0002, … one per cycle.
2. Hold stall_i=1 for 6 cycles starting when origaddr_o=0003 → head stays 0003; count_o saturates at 4; fe_o=0 once count+inflight=4. Release → 0004…0007 appear consecutively with no gap or duplicate.
3. branch_i=1 with baddr_i=0040 while count=3 → v_o=0 the next cycle; addr_o=0040; the stale response is dropped; v_o=1 with origaddr 0040 three cycles after the branch, then 0041.
4. branch_i=1 together with stall_i=1 → branch wins: FIFO flushed and redirect to the target.
5. Branches in consecutive cycles to 0080 then 0100 → the first delivered instruction is 0100; 0080 never appears.
6. pc=FFFF → next fetch addr_o=0000. Assert rst=0 mid-burst → v_o and count_o clear immediately; the first fetch after release is RESET_ADDR.
